// File: rtl/not4_pkg.sv
// Shared definitions for the inverter checker: FSM state encoding, counter
// width and the saturating counter step.
package not4_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/not4_ref_cmp.sv
// Golden comparison for one inverter sample: flags any bit where the response
// is not the complement of the stimulus.
module not4_ref_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  output logic             mismatch
);

  assign mismatch = (y != ~a);

endmodule

// File: rtl/not4_checker.sv
// Run-based checker for a WIDTH-bit inverter: accepts NUM_VEC sample pairs,
// counts mismatches and captures the first failing pair.
module not4_checker
  import not4_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_VEC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_y,
  output logic             in_ready,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_seen,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_y
);

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] ffa_q, ffa_d;
  logic [WIDTH-1:0] ffy_q, ffy_d;
  logic             mismatch;
  logic             accept;
  logic             clear;

  not4_ref_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a        (in_a),
    .y        (in_y),
    .mismatch (mismatch)
  );

  assign in_ready = (state_q == RUN);
  assign accept   = in_valid && in_ready;
  // start is only honoured outside a run; mid-run pulses are dropped.
  assign clear    = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fail_d  = fail_q;
    done_d  = done_q;
    pass_d  = pass_q;
    ffa_d   = ffa_q;
    ffy_d   = ffy_q;

    if (clear) begin
      state_d = RUN;
      vec_d   = '0;
      err_d   = '0;
      fail_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      ffa_d   = '0;
      ffy_d   = '0;
    end else if (accept) begin
      vec_d = vec_q + CNT_W'(1);
      if (mismatch) begin
        err_d = sat_inc(err_q);
        if (!fail_q) begin
          fail_d = 1'b1;
          ffa_d  = in_a;
          ffy_d  = in_y;
        end
      end
      // Verdict is formed on the accepting edge so it includes the last sample.
      if (vec_d == LAST_VEC) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = !fail_d;
      end
    end

    if (!(state_q inside {IDLE, RUN, DONE})) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ffa_q   <= '0;
      ffy_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ffa_q   <= ffa_d;
      ffy_q   <= ffy_d;
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign vec_count    = vec_q;
  assign err_count    = err_q;
  assign fail_seen    = fail_q;
  assign first_fail_a = ffa_q;
  assign first_fail_y = ffy_q;

endmodule

// File: tb/tb_not4_checker.sv
// Bench for not4_checker: directed vector table, hand-written reset sequence,
// and randomized traffic compared against a queue-based run model.
module tb_not4_checker;

  localparam int W  = 4;
  localparam int NV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_y;
  logic         in_ready;
  logic         done;
  logic         pass;
  logic [7:0]   vec_count;
  logic [7:0]   err_count;
  logic         fail_seen;
  logic [W-1:0] first_fail_a;
  logic [W-1:0] first_fail_y;

  not4_checker #(.WIDTH(W), .NUM_VEC(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_a         (in_a),
    .in_y         (in_y),
    .in_ready     (in_ready),
    .done         (done),
    .pass         (pass),
    .vec_count    (vec_count),
    .err_count    (err_count),
    .fail_seen    (fail_seen),
    .first_fail_a (first_fail_a),
    .first_fail_y (first_fail_y)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       st;
    logic       v;
    logic [3:0] a;
    logic [3:0] y;
    logic       rdy;
    logic [7:0] vec;
    logic [7:0] err;
    logic       fl;
    logic [3:0] fa;
    logic [3:0] fy;
    logic       dn;
    logic       ps;
  } row_t;

  row_t tbl [19];

  // Run model: the list of pairs accepted in the current run.
  logic [W-1:0] qa[$];
  logic [W-1:0] qy[$];
  bit           m_run;
  bit           m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic [7:0] vec,
                           input logic [7:0] err, input logic fl, input logic [3:0] fa,
                           input logic [3:0] fy, input logic dn, input logic ps);
    chk({tag, ".in_ready"},     32'(in_ready),     32'(rdy));
    chk({tag, ".vec_count"},    32'(vec_count),    32'(vec));
    chk({tag, ".err_count"},    32'(err_count),    32'(err));
    chk({tag, ".fail_seen"},    32'(fail_seen),    32'(fl));
    chk({tag, ".first_fail_a"}, 32'(first_fail_a), 32'(fa));
    chk({tag, ".first_fail_y"}, 32'(first_fail_y), 32'(fy));
    chk({tag, ".done"},         32'(done),         32'(dn));
    chk({tag, ".pass"},         32'(pass),         32'(ps));
  endtask

  task automatic apply(input logic s, input logic v, input logic [W-1:0] a, input logic [W-1:0] y);
    @(negedge clk);
    start    = s;
    in_valid = v;
    in_a     = a;
    in_y     = y;
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    int         errs;
    logic [3:0] fa;
    logic [3:0] fy;
    bit         found;
    errs  = 0;
    fa    = '0;
    fy    = '0;
    found = 0;
    for (int i = 0; i < qa.size(); i++) begin
      if ((qa[i] ^ qy[i]) != 4'hF) begin
        errs++;
        if (!found) begin
          found = 1;
          fa    = qa[i];
          fy    = qy[i];
        end
      end
    end
    if (errs > 255) errs = 255;
    check_all(tag, m_run, 8'(qa.size()), 8'(errs), found, fa, fy, m_done,
              m_done && (errs == 0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_y = '0;

    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 8'd1, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'hA, 4'h5, 1'b1, 8'd2, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 8'd3, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'hC, 4'h3, 1'b0, 8'd4, 8'd0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'd4, 8'd0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 8'd1, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'hA, 4'h7, 1'b1, 8'd2, 8'd1, 1'b1, 4'hA, 4'h7, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b1, 8'd3, 8'd1, 1'b1, 4'hA, 4'h7, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'hC, 4'hC, 1'b0, 8'd4, 8'd2, 1'b1, 4'hA, 4'h7, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'h3, 4'h3, 1'b1, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 8'd1, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h5, 4'h5, 1'b1, 8'd1, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'hA, 4'h5, 1'b1, 8'd2, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 8'd3, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'hC, 4'hC, 1'b1, 8'd3, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 4'hC, 4'h3, 1'b0, 8'd4, 8'd0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1};

    // Reset values, then valid traffic in IDLE must be ignored.
    #2;
    check_all("reset", 1'b0, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b1, 4'hA, 4'h7);
    check_all("idle_valid", 1'b0, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].y);
      check_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].vec, tbl[i].err, tbl[i].fl,
                tbl[i].fa, tbl[i].fy, tbl[i].dn, tbl[i].ps);
    end

    // Asynchronous reset after two accepted samples, checked before any clock edge.
    apply(1'b1, 1'b0, 4'h0, 4'h0);
    apply(1'b0, 1'b1, 4'hA, 4'h7);
    apply(1'b0, 1'b1, 4'h0, 4'hF);
    check_all("pre_rst", 1'b1, 8'd2, 8'd1, 1'b1, 4'hA, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b1, 4'h0, 4'hF);
    check_all("post_rst_idle", 1'b0, 8'd0, 8'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Randomized traffic against the run model (DUT is in IDLE with empty counters).
    qa.delete(); qy.delete();
    m_run = 0; m_done = 0;
    for (int c = 0; c < 400; c++) begin
      logic         s;
      logic         v;
      logic [W-1:0] a;
      logic [W-1:0] y;
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        qa.delete(); qy.delete();
        m_run = 0; m_done = 0;
        model_check($sformatf("rnd_rst%0d", c));
        @(negedge clk);
        rst = 1'b0;
      end else begin
        s = ($urandom_range(0, 7) == 0);
        v = ($urandom_range(0, 3) != 0);
        a = W'($urandom);
        y = ($urandom_range(0, 4) == 0) ? W'($urandom) : W'(4'hF - a);
        apply(s, v, a, y);
        if (!m_run && s) begin
          qa.delete(); qy.delete();
          m_run  = 1;
          m_done = 0;
        end else if (m_run && v) begin
          qa.push_back(a);
          qy.push_back(y);
          if (qa.size() == NV) begin
            m_run  = 0;
            m_done = 1;
          end
        end
        model_check($sformatf("rnd%0d", c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
